redirect_gen: RTL and testbench

REDIRECT_GEN -- requirements
Module: redirect_gen

---
 rtl/redirect_gen_pkg.sv | 20 ++
 rtl/redirect_perf_cnt.sv | 42 ++++
 rtl/redirect_gen.sv | 132 +++++++++++++
 tb/tb_redirect_gen.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/redirect_gen_pkg.sv
// ============================================================================
// redirect_gen_pkg -- shared CPU types for the fetch redirect logic. Rev 1.0
// ============================================================================
`default_nettype none

`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif

package redirect_gen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_DS = 2'd1,
    HOLD    = 2'd2
  } redirect_state_t;

endpackage

`default_nettype wire

// File: rtl/redirect_perf_cnt.sv
// ============================================================================
// redirect_perf_cnt -- wrapping 32-bit counters of accepted redirects. Rev 1.0
// ============================================================================
`default_nettype none

module redirect_perf_cnt
  import redirect_gen_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_acc_i,
  input  logic        flush_acc_i,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] flush_cnt_o
);

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] flush_cnt_q,  flush_cnt_d;

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (branch_acc_i) branch_cnt_d = branch_cnt_q + 32'd1;
    if (flush_acc_i)  flush_cnt_d  = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt_q <= `ZeroWord;
      flush_cnt_q  <= `ZeroWord;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign branch_cnt_o = branch_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;

endmodule

`default_nettype wire

// File: rtl/redirect_gen.sv
// ============================================================================
// redirect_gen -- branch/flush redirect generator for next-pc select. Rev 1.0
// Optional counters under macro REDIRECT_PERF_EN.
// ============================================================================
`default_nettype none

module redirect_gen
  import redirect_gen_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_valid_i,
  input  logic [31:0] branch_target_i,
  input  logic        ds_fetched_i,
  input  logic        exc_valid_i,
  input  logic [31:0] exc_pc_i,
  input  logic        if_stall_i,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        branch_flag_o,
  output logic [31:0] branch_to_addr_o,
  output logic        busy_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] flush_cnt_o
);

  redirect_state_t state_q, state_d;
  logic [31:0]     target_q, target_d;
  logic            flush_pend_q, flush_pend_d;
  logic [31:0]     flush_pc_q, flush_pc_d;

  logic            flush_act;
  logic [31:0]     flush_addr;
  logic            br_fire;
  logic [31:0]     br_addr;

  always_comb begin
    flush_act  = exc_valid_i | flush_pend_q;
    // A fresh exception always wins over the registered one
    flush_addr = exc_valid_i ? exc_pc_i : flush_pc_q;
    br_fire    = 1'b0;
    br_addr    = `ZeroWord;
    state_d    = state_q;
    target_d   = target_q;

    case (state_q)
      IDLE: begin
        if (branch_valid_i && !flush_act) begin
          target_d = branch_target_i;
          if (ds_fetched_i) begin
            br_fire = 1'b1;
            br_addr = branch_target_i;
            if (if_stall_i) state_d = HOLD;
          end else begin
            state_d = WAIT_DS;
          end
        end
      end
      WAIT_DS: begin
        if (ds_fetched_i && !flush_act) begin
          br_fire = 1'b1;
          br_addr = target_q;
          state_d = if_stall_i ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (!flush_act) begin
          br_fire = 1'b1;
          br_addr = target_q;
          if (!if_stall_i) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Any flush drops a captured branch
    if (flush_act) state_d = IDLE;
    if (state_d == IDLE) target_d = `ZeroWord;

    flush_pend_d = flush_act & if_stall_i;
    flush_pc_d   = flush_pend_d ? flush_addr : `ZeroWord;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      target_q     <= `ZeroWord;
      flush_pend_q <= 1'b0;
      flush_pc_q   <= `ZeroWord;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      flush_pend_q <= flush_pend_d;
      flush_pc_q   <= flush_pc_d;
    end
  end

  assign flush_o          = ~rst_i & flush_act;
  assign new_pc_o         = flush_o ? flush_addr : `ZeroWord;
  assign branch_flag_o    = ~rst_i & br_fire;
  assign branch_to_addr_o = branch_flag_o ? br_addr : `ZeroWord;
  assign busy_o           = ~rst_i & ((state_q != IDLE) | flush_pend_q);

`ifdef REDIRECT_PERF_EN
  logic        branch_acc;
  logic        flush_acc;
  logic [31:0] branch_cnt;
  logic [31:0] flush_cnt;

  // branch_flag_o is already suppressed by any flush, so a dropped branch never counts
  assign branch_acc = branch_flag_o & ~if_stall_i;
  assign flush_acc  = flush_o & ~if_stall_i;

  redirect_perf_cnt u_perf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .branch_acc_i (branch_acc),
    .flush_acc_i  (flush_acc),
    .branch_cnt_o (branch_cnt),
    .flush_cnt_o  (flush_cnt)
  );

  assign branch_cnt_o = rst_i ? `ZeroWord : branch_cnt;
  assign flush_cnt_o  = rst_i ? `ZeroWord : flush_cnt;
`else
  assign branch_cnt_o = `ZeroWord;
  assign flush_cnt_o  = `ZeroWord;
`endif

endmodule

`default_nettype wire

// File: tb/tb_redirect_gen.sv
// ============================================================================
// tb_redirect_gen -- directed self-checking bench for redirect_gen. Rev 1.0
// ============================================================================
`default_nettype none

module tb_redirect_gen;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        branch_valid_i;
  logic [31:0] branch_target_i;
  logic        ds_fetched_i;
  logic        exc_valid_i;
  logic [31:0] exc_pc_i;
  logic        if_stall_i;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        branch_flag_o;
  logic [31:0] branch_to_addr_o;
  logic        busy_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] flush_cnt_o;

  int total = 0;
  int bad   = 0;

  redirect_gen dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .branch_valid_i   (branch_valid_i),
    .branch_target_i  (branch_target_i),
    .ds_fetched_i     (ds_fetched_i),
    .exc_valid_i      (exc_valid_i),
    .exc_pc_i         (exc_pc_i),
    .if_stall_i       (if_stall_i),
    .flush_o          (flush_o),
    .new_pc_o         (new_pc_o),
    .branch_flag_o    (branch_flag_o),
    .branch_to_addr_o (branch_to_addr_o),
    .busy_o           (busy_o),
    .branch_cnt_o     (branch_cnt_o),
    .flush_cnt_o      (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Apply one cycle of inputs at the falling edge, settle, then let the caller check
  task automatic step(input logic bv, input logic [31:0] bt, input logic ds,
                      input logic ev, input logic [31:0] epc, input logic st);
    @(negedge clk_i);
    branch_valid_i  = bv;
    branch_target_i = bt;
    ds_fetched_i    = ds;
    exc_valid_i     = ev;
    exc_pc_i        = epc;
    if_stall_i      = st;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step(1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'h8765_4321, 1'b0);
    total++;
    if ({flush_o, branch_flag_o, busy_o, new_pc_o, branch_to_addr_o} !== 67'd0) begin
      bad++;
      $display("FAIL reset_outputs flush=%b flag=%b busy=%b new_pc=%h addr=%h want all 0",
               flush_o, branch_flag_o, busy_o, new_pc_o, branch_to_addr_o);
    end
    total++;
    if ({branch_cnt_o, flush_cnt_o} !== 64'd0) begin
      bad++;
      $display("FAIL reset_counters bcnt=%h fcnt=%h want 0", branch_cnt_o, flush_cnt_o);
    end
    rst_i = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    total++;
    if ({busy_o, branch_flag_o, flush_o} !== 3'b000) begin
      bad++;
      $display("FAIL after_reset busy=%b flag=%b flush=%b want 000", busy_o, branch_flag_o, flush_o);
    end
  endtask

  task automatic test_branch_immediate();
    step(1'b1, 32'hBFC0_0100, 1'b1, 1'b0, 32'h0, 1'b0);
    total++;
    if (branch_flag_o !== 1'b1 || branch_to_addr_o !== 32'hBFC0_0100 || flush_o !== 1'b0) begin
      bad++;
      $display("FAIL br_imm flag=%b addr=%h flush=%b want 1 bfc00100 0",
               branch_flag_o, branch_to_addr_o, flush_o);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    total++;
    if (branch_flag_o !== 1'b0 || branch_to_addr_o !== 32'h0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL br_imm_next flag=%b addr=%h busy=%b want 0 0 0",
               branch_flag_o, branch_to_addr_o, busy_o);
    end
  endtask

  task automatic test_branch_wait_ds();
    step(1'b1, 32'h8000_1000, 1'b0, 1'b0, 32'h0, 1'b0);
    total++;
    if (branch_flag_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL wds_capture flag=%b busy=%b want 0 0", branch_flag_o, busy_o);
    end
    // A second branch while waiting must not replace the captured target
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
    total++;
    if (branch_flag_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL wds_wait flag=%b busy=%b want 0 1", branch_flag_o, busy_o);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, (i == 0), 1'b0, 32'h0, (i < 3));
      total++;
      if (branch_flag_o !== 1'b1 || branch_to_addr_o !== 32'h8000_1000) begin
        bad++;
        $display("FAIL wds_hold[%0d] flag=%b addr=%h want 1 80001000",
                 i, branch_flag_o, branch_to_addr_o);
      end
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    total++;
    if (branch_flag_o !== 1'b0 || busy_o !== 1'b0 || branch_to_addr_o !== 32'h0) begin
      bad++;
      $display("FAIL wds_done flag=%b busy=%b addr=%h want 0 0 0",
               branch_flag_o, busy_o, branch_to_addr_o);
    end
  endtask

  task automatic test_flush_override();
    step(1'b1, 32'h8000_2000, 1'b1, 1'b0, 32'h0, 1'b1);
    total++;
    if (branch_flag_o !== 1'b1 || branch_to_addr_o !== 32'h8000_2000) begin
      bad++;
      $display("FAIL fo_branch flag=%b addr=%h want 1 80002000", branch_flag_o, branch_to_addr_o);
    end
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'hBFC0_0380, 1'b0);
    total++;
    if (flush_o !== 1'b1 || new_pc_o !== 32'hBFC0_0380 ||
        branch_flag_o !== 1'b0 || branch_to_addr_o !== 32'h0) begin
      bad++;
      $display("FAIL fo_flush flush=%b pc=%h flag=%b addr=%h want 1 bfc00380 0 0",
               flush_o, new_pc_o, branch_flag_o, branch_to_addr_o);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    total++;
    if (branch_flag_o !== 1'b0 || flush_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL fo_dropped flag=%b flush=%b busy=%b want 0 0 0",
               branch_flag_o, flush_o, busy_o);
    end
  endtask

  task automatic test_stalled_flush();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b0, (i == 0), (i == 0) ? 32'hBFC0_0380 : 32'h0, (i < 2));
      total++;
      if (flush_o !== 1'b1 || new_pc_o !== 32'hBFC0_0380) begin
        bad++;
        $display("FAIL sf_hold[%0d] flush=%b pc=%h want 1 bfc00380", i, flush_o, new_pc_o);
      end
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    total++;
    if (flush_o !== 1'b0 || new_pc_o !== 32'h0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL sf_clear flush=%b pc=%h busy=%b want 0 0 0", flush_o, new_pc_o, busy_o);
    end
    // Newer exception overwrites the pending one; simultaneous branch is blocked
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_0000, 1'b1);
    step(1'b1, 32'h1234_5678, 1'b0, 1'b1, 32'hA000_0180, 1'b1);
    total++;
    if (flush_o !== 1'b1 || new_pc_o !== 32'hA000_0180 || branch_flag_o !== 1'b0) begin
      bad++;
      $display("FAIL sf_newer flush=%b pc=%h flag=%b want 1 a0000180 0",
               flush_o, new_pc_o, branch_flag_o);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    total++;
    if (flush_o !== 1'b1 || new_pc_o !== 32'hA000_0180) begin
      bad++;
      $display("FAIL sf_overwrite flush=%b pc=%h want 1 a0000180", flush_o, new_pc_o);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    total++;
    if (busy_o !== 1'b0 || branch_flag_o !== 1'b0 || flush_o !== 1'b0) begin
      bad++;
      $display("FAIL sf_no_capture busy=%b flag=%b flush=%b want 0 0 0",
               busy_o, branch_flag_o, flush_o);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 32'h8000_3000, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_i = 1'b1;
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'hBFC0_0200, 1'b0);
    total++;
    if ({flush_o, branch_flag_o, busy_o, new_pc_o, branch_to_addr_o} !== 67'd0) begin
      bad++;
      $display("FAIL rm_during flush=%b flag=%b busy=%b pc=%h addr=%h want all 0",
               flush_o, branch_flag_o, busy_o, new_pc_o, branch_to_addr_o);
    end
    rst_i = 1'b0;
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    total++;
    if (branch_flag_o !== 1'b0 || busy_o !== 1'b0 || flush_o !== 1'b0) begin
      bad++;
      $display("FAIL rm_after flag=%b busy=%b flush=%b want 0 0 0", branch_flag_o, busy_o, flush_o);
    end
  endtask

  task automatic test_counters();
    step(1'b1, 32'h1111_0000, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h2222_0000, 1'b0);
    step(1'b1, 32'h3333_0000, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h4444_0000, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
`ifdef REDIRECT_PERF_EN
    total++;
    if (branch_cnt_o !== 32'd1 || flush_cnt_o !== 32'd2) begin
      bad++;
      $display("FAIL cnt_values bcnt=%0d fcnt=%0d want 1 2", branch_cnt_o, flush_cnt_o);
    end
    @(negedge clk_i);
    force dut.u_perf.branch_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_perf.branch_cnt_q;
    step(1'b1, 32'h5555_0000, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    total++;
    if (branch_cnt_o !== 32'd0 || flush_cnt_o !== 32'd2) begin
      bad++;
      $display("FAIL cnt_wrap bcnt=%h fcnt=%0d want 00000000 2", branch_cnt_o, flush_cnt_o);
    end
`else
    total++;
    if (branch_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
      bad++;
      $display("FAIL cnt_disabled bcnt=%h fcnt=%h want 0 0", branch_cnt_o, flush_cnt_o);
    end
    step(1'b1, 32'h5555_0000, 1'b1, 1'b1, 32'h6666_0000, 1'b0);
    total++;
    if (branch_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
      bad++;
      $display("FAIL cnt_disabled2 bcnt=%h fcnt=%h want 0 0", branch_cnt_o, flush_cnt_o);
    end
`endif
  endtask

  initial begin
    rst_i           = 1'b1;
    branch_valid_i  = 1'b0;
    branch_target_i = 32'h0;
    ds_fetched_i    = 1'b0;
    exc_valid_i     = 1'b0;
    exc_pc_i        = 32'h0;
    if_stall_i      = 1'b0;
    test_reset();
    test_branch_immediate();
    test_branch_wait_ds();
    test_flush_override();
    test_stalled_flush();
    test_reset_mid();
    test_counters();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
